led_fade_driver: RTL and testbench
==================================

// Module: led_fade_driver
// PURPOSE
//  Downstream consumer of the 8-bit LED register field driven by the AXI-Lite register block.
//  Converts each on/off request bit into a PWM pad drive with a linear soft fade between
//  0% and 100% brightness. Sits between the register-block output and the board LED pins.
// PARAMETERS
//  NUM_LEDS  8   number of LED channels (request bits / pads)
//  PWM_BITS  8   duty/PWM counter width; MAXD = 2**PWM_BITS-1
//  PRESCALE  16  clk cycles per PWM counter step (>=1)
//  FADE_DIV  4   PWM periods per fade step (>=1)
// PORTS
//  clk       in   1         system clock
//  rst       in   1         asynchronous, active-low reset
//  led_req   in   NUM_LEDS  requested state per LED (1 = on), from register block
//  fade_en   in   1         1 = fade towards target; 0 = snap to target
//  led_pad   out  NUM_LEDS  registered PWM drive to pins (1 = lit)
//  busy      out  1         registered; 1 while any duty != its target
// BEHAVIOUR
//  Reset (rst=0, async): presc_cnt=0, pwm_cnt=0, fade_cnt=0, all duty[i]=0, led_pad=0, busy=0.
//  Prescaler: presc_cnt counts 0..PRESCALE-1; tick=1 in the cycle presc_cnt==PRESCALE-1.
//   PRESCALE==1: tick every cycle.
//  PWM counter: pwm_cnt += 1 on tick, wraps MAXD->0. wrap = tick && pwm_cnt==MAXD.
//   PWM period = PRESCALE*2**PWM_BITS clk cycles.
//  Fade counter: fade_cnt counts wraps 0..FADE_DIV-1; step = wrap && fade_cnt==FADE_DIV-1.
//  Per-LED target tgt[i] = led_req[i] ? MAXD : 0, sampled every cycle (no latching).
//  Duty update, each clk, per LED, evaluated in this order:
//   fade_en==0         : duty[i] <= tgt[i] (next cycle, independent of step)
//   fade_en==1 && step : duty[i] moves 1 toward tgt[i]; no change if equal; no wrap/overflow
//   otherwise          : hold
//  led_req toggling mid-fade: direction reverses at next step from the current duty.
//   No restart of counters.
//  Compare: lit[i] = (duty[i]==MAXD) || (duty[i] > pwm_cnt). duty 0 -> never lit;
//   MAXD -> always lit.
//  led_pad <= lit (one register stage; pad lags counter/duty state by 1 clk).
//  busy <= |(duty != tgt) evaluated on current regs (1-cycle lag vs duty change).
//  Counters free-run regardless of led_req/fade_en; fade_en toggling does not reset them.
//  Full fade 0->MAXD with fade_en=1: MAXD steps; FADE_DIV PWM periods per step.
// CONFIGURATION
//  LED_FADE_GAMMA_EN defined: compare uses eff[i] = (duty[i]*duty[i]) >> PWM_BITS
//   (2*PWM_BITS-bit product, unsigned).
//   lit[i] = (duty[i]==MAXD) || (eff[i] > pwm_cnt). Perceptual square-law brightness.
//   Duty/fade/busy behaviour unchanged.
//  LED_FADE_GAMMA_EN undefined: linear compare as above; no multiplier inferred.
// TESTING (bench params PRESCALE=2, FADE_DIV=1, PWM_BITS=8 unless noted)
//  1 Reset: assert rst=0 mid-run with led_req=8'hFF -> led_pad=0, busy=0 immediately (async).
//    Release: counters restart at 0.
//  2 Snap: fade_en=0, led_req 0x00->0xA5 -> busy=1 for exactly 1 cycle.
//    Pads for bits 0,2,5,7 constant 1 from 2 clks after change; others constant 0.
//  3 Fade up: fade_en=1, led_req[0]=1 from reset -> duty[0] increments once per 512 clk.
//    Duty=128 after 128 steps: pad[0] high 256 of 512 cycles. busy drops after 255 steps.
//  4 Reversal: fade up to duty=10, then led_req[0]=0 -> duty 9 at next step.
//    Reaches 0 after 10 steps, busy=0, pad[0] stays 0.
//  5 Wrap/boundary: duty=MAXD -> pad high every cycle incl. pwm_cnt=MAXD.
//    duty=1 -> pad high only when pwm_cnt==0 (2 clk/period).
//  6 LED_FADE_GAMMA_EN: duty=128 -> eff=64 -> pad high 128 of 512 clk.
//    duty=15 -> eff=0 -> pad never high.

Source files
------------

// File: rtl/led_fade_driver.sv
// led_fade_driver
//   Turns per-LED on/off requests from the register block into PWM pad drive
//   with a linear soft fade between 0% and 100% brightness.
//
//   Parameters
//     NUM_LEDS  number of LED channels
//     PWM_BITS  duty / PWM counter width (MAXD = 2**PWM_BITS-1)
//     PRESCALE  clk cycles per PWM counter step (>=1)
//     FADE_DIV  PWM periods per fade step (>=1)
//
//   Ports
//     clk      system clock
//     rst      asynchronous active-low reset
//     led_req  requested state per LED (1 = on)
//     fade_en  1 = fade towards target one duty step per fade step, 0 = snap
//     led_pad  registered PWM drive to pins (1 = lit)
//     busy     registered, 1 while any duty differs from its target
//
//   Build option
//     LED_FADE_GAMMA_EN  when defined, the PWM compare uses the square-law
//                        effective duty (duty*duty >> PWM_BITS).
module led_fade_driver #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned FADE_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_LEDS-1:0] led_req,
  input  logic                fade_en,
  output logic [NUM_LEDS-1:0] led_pad,
  output logic                busy
);

  localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned FAD_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  localparam logic [PWM_BITS-1:0] MAXD      = '1;
  localparam logic [PSC_W-1:0]    PSC_LAST  = PSC_W'(PRESCALE - 1);
  localparam logic [FAD_W-1:0]    FADE_LAST = FAD_W'(FADE_DIV - 1);

  logic [PSC_W-1:0]                   presc_cnt;
  logic [PWM_BITS-1:0]                pwm_cnt;
  logic [FAD_W-1:0]                   fade_cnt;
  logic                               tick;
  logic                               wrap;
  logic                               step;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  duty;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  tgt;
  logic [NUM_LEDS-1:0]                lit;
  logic [NUM_LEDS-1:0]                mismatch;
`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0]              prod;
  logic [PWM_BITS-1:0]                eff;
`endif

  // With PRESCALE==1 the prescaler is pinned at 0 == PSC_LAST, so tick is
  // asserted every cycle.
  always_comb begin
    tick = (presc_cnt == PSC_LAST);
    wrap = tick && (pwm_cnt == MAXD);
    step = wrap && (fade_cnt == FADE_LAST);
  end

  always_comb begin
    tgt      = '0;
    lit      = '0;
    mismatch = '0;
`ifdef LED_FADE_GAMMA_EN
    prod     = '0;
    eff      = '0;
`endif
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      tgt[i]      = led_req[i] ? MAXD : '0;
      mismatch[i] = (duty[i] != tgt[i]);
`ifdef LED_FADE_GAMMA_EN
      prod   = {{PWM_BITS{1'b0}}, duty[i]} * {{PWM_BITS{1'b0}}, duty[i]};
      eff    = prod[2*PWM_BITS-1:PWM_BITS];
      lit[i] = (duty[i] == MAXD) || (eff > pwm_cnt);
`else
      // MAXD is forced lit so full brightness has no dark slot at pwm_cnt==MAXD.
      lit[i] = (duty[i] == MAXD) || (duty[i] > pwm_cnt);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      fade_cnt  <= '0;
      duty      <= '0;
      led_pad   <= '0;
      busy      <= 1'b0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      if (wrap) begin
        fade_cnt <= step ? '0 : fade_cnt + 1'b1;
      end
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        if (!fade_en) begin
          duty[i] <= tgt[i];
        end else if (step) begin
          if (duty[i] < tgt[i]) begin
            duty[i] <= duty[i] + 1'b1;
          end else if (duty[i] > tgt[i]) begin
            duty[i] <= duty[i] - 1'b1;
          end
        end
      end
      led_pad <= lit;
      busy    <= |mismatch;
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// tb_led_fade_driver
//   Randomized and directed stimulus for led_fade_driver, checked every cycle
//   against a cycle-count based reference model, plus per-period lit-cycle
//   counts at chosen duty levels.
module tb_led_fade_driver;

  localparam int NUM      = 8;
  localparam int PRESCALE = 2;
  localparam int FADE_DIV = 1;
  localparam int MAXD     = 255;
  localparam int PERIOD   = PRESCALE * 256;
  localparam int STEP_CYC = PERIOD * FADE_DIV;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NUM-1:0] led_req = '0;
  logic           fade_en = 1'b1;
  logic [NUM-1:0] led_pad;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  led_fade_driver #(
    .NUM_LEDS (NUM),
    .PWM_BITS (8),
    .PRESCALE (PRESCALE),
    .FADE_DIV (FADE_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .led_req (led_req),
    .fade_en (fade_en),
    .led_pad (led_pad),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff_of(input int d);
`ifdef LED_FADE_GAMMA_EN
    return (d * d) >> 8;
`else
    return d;
`endif
  endfunction

  // Lit cycles in one PWM period at a constant duty.
  function automatic int exp_hits(input int d);
    if (d == MAXD) return PERIOD;
    return PRESCALE * eff_of(d);
  endfunction

  // Reference model: counter state derived from cycles since reset.
  int unsigned m_t = 0;
  int          m_duty [NUM];
  logic [NUM-1:0] m_pad = '0;
  logic        m_busy = 1'b0;
  int          m_pwm;
  bit          m_step;
  int          m_tgt;
  logic [NUM-1:0] m_lit;
  logic        m_bn;

  initial foreach (m_duty[i]) m_duty[i] = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_t = 0;
      foreach (m_duty[i]) m_duty[i] = 0;
      m_pad  = '0;
      m_busy = 1'b0;
    end else begin
      m_pwm  = int'((m_t / PRESCALE) % 256);
      m_step = ((m_t % STEP_CYC) == STEP_CYC - 1);
      m_bn   = 1'b0;
      for (int i = 0; i < NUM; i++) begin
        m_tgt    = led_req[i] ? MAXD : 0;
        m_lit[i] = (m_duty[i] == MAXD) || (eff_of(m_duty[i]) > m_pwm);
        if (m_duty[i] != m_tgt) m_bn = 1'b1;
        if (!fade_en) m_duty[i] = m_tgt;
        else if (m_step) begin
          if (m_duty[i] < m_tgt) m_duty[i] = m_duty[i] + 1;
          else if (m_duty[i] > m_tgt) m_duty[i] = m_duty[i] - 1;
        end
      end
      m_pad  = m_lit;
      m_busy = m_bn;
      m_t    = m_t + 1;
    end
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("pad", 32'(led_pad), 32'(m_pad));
      check("busy", 32'(busy), 32'(m_busy));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_pad", 32'(led_pad), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_duty(input int d, input int budget);
    int k = 0;
    while (m_duty[0] != d && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (m_duty[0] != d) check("wait_duty_timeout", 32'(m_duty[0]), 32'(d));
  endtask

  // Counts led_pad[0] over one PWM period starting on a fade-step boundary,
  // so duty is constant throughout the window.
  task automatic measure(input string tag, input int d);
    int k = 0;
    int cnt = 0;
    while ((m_t % STEP_CYC) != 0 && k < 2 * STEP_CYC) begin
      @(negedge clk);
      k++;
    end
    if ((m_t % STEP_CYC) != 0) check("align_timeout", 32'(m_t % STEP_CYC), 0);
    repeat (PERIOD) begin
      @(negedge clk);
      cnt += int'(led_pad[0]);
    end
    check(tag, 32'(cnt), 32'(exp_hits(d)));
  endtask

  initial begin
    int cnt;
    int n;
    #1 rst = 1'b0;
    #20;
    check("init_pad", 32'(led_pad), 0);
    check("init_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    // Random requests and mode changes, model-checked each cycle.
    repeat (120) begin
      led_req = NUM'($urandom);
      fade_en = 1'($urandom);
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    // Asynchronous reset while fully lit.
    fade_en = 1'b0;
    led_req = '1;
    repeat (4) @(negedge clk);
    check("lit_before_rst", 32'(led_pad), 32'hFF);
    do_reset();

    // Snap: busy for one cycle, pads follow the request pattern.
    led_req = '0;
    repeat (4) @(negedge clk);
    led_req = 8'hA5;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(busy);
    end
    check("snap_busy_cycles", 32'(cnt), 1);
    check("snap_pad", 32'(led_pad), 32'hA5);

    // Fade up from reset, then reverse at duty 10.
    fade_en = 1'b1;
    led_req = 8'h01;
    do_reset();
    wait_duty(10, 12 * STEP_CYC);
    led_req = 8'h00;
    measure("hold_duty10", 10);
    measure("reversed_duty9", 9);
    check("busy_mid_fade", 32'(busy), 1);
    wait_duty(0, 12 * STEP_CYC);
    repeat (3) @(negedge clk);
    check("busy_after_fade", 32'(busy), 0);
    check("pad_after_fade", 32'(led_pad), 0);

    // Full brightness: lit through every slot including pwm_cnt==MAXD.
    fade_en = 1'b0;
    led_req = 8'h01;
    repeat (4) @(negedge clk);
    measure("duty_max", MAXD);

    // Random-length fade down from full.
    fade_en = 1'b1;
    led_req = 8'h00;
    n = $urandom_range(3, 12);
    wait_duty(MAXD - n, (n + 2) * STEP_CYC);
    measure("fade_down", MAXD - n);

    // Lowest non-zero duty.
    led_req = 8'h01;
    do_reset();
    wait_duty(1, 3 * STEP_CYC);
    measure("duty_one", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
